// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, address-width derivation and read-result type for the renamed register file.
package rf_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W = 5;
    localparam int DEF_NUM_REGS = 32;
    function automatic int rf_aw(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEF_AW = rf_aw(DEF_NUM_REGS);
    typedef struct packed {
        logic ready;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_DATA_W-1:0] value;
    } rf_read_t;
endpackage

// File: rtl/renamed_register_file_if.sv
// renamed_register_file_if: bus between decode/issue + ROB commit (master) and the register file (slave).
// Ports: rdy, flush, rename_{en,addr,tag}, commit_{en,addr,tag,data} (flat per port),
//        read_addr (flat per port), read_{ready,tag,value} (flat per port), busy_count.
interface renamed_register_file_if #(
    parameter int DATA_W = rf_pkg::DEF_DATA_W,
    parameter int TAG_W = rf_pkg::DEF_TAG_W,
    parameter int NUM_REGS = rf_pkg::DEF_NUM_REGS,
    parameter int NUM_READ = 2,
    parameter int NUM_COMMIT = 2
);
    import rf_pkg::*;
    localparam int AW = rf_aw(NUM_REGS);
    localparam int CW = rf_aw(NUM_REGS + 1);
    logic rdy;
    logic flush;
    logic rename_en;
    logic [AW-1:0] rename_addr;
    logic [TAG_W-1:0] rename_tag;
    logic [NUM_COMMIT-1:0] commit_en;
    logic [NUM_COMMIT*AW-1:0] commit_addr;
    logic [NUM_COMMIT*TAG_W-1:0] commit_tag;
    logic [NUM_COMMIT*DATA_W-1:0] commit_data;
    logic [NUM_READ*AW-1:0] read_addr;
    logic [NUM_READ-1:0] read_ready;
    logic [NUM_READ*TAG_W-1:0] read_tag;
    logic [NUM_READ*DATA_W-1:0] read_value;
    logic [CW-1:0] busy_count;
    modport master(
        output rdy, flush, rename_en, rename_addr, rename_tag,
        output commit_en, commit_addr, commit_tag, commit_data, read_addr,
        input read_ready, read_tag, read_value, busy_count
    );
    modport slave(
        input rdy, flush, rename_en, rename_addr, rename_tag,
        input commit_en, commit_addr, commit_tag, commit_data, read_addr,
        output read_ready, read_tag, read_value, busy_count
    );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one source-operand lookup with same-cycle commit bypass.
// Ports: addr in; busy/tags/values (entry state) in; rdy + commit_* in;
//        ready/tag/value out (tag only when waiting, value only when ready).
module rf_read_port #(
    parameter int DATA_W = rf_pkg::DEF_DATA_W,
    parameter int TAG_W = rf_pkg::DEF_TAG_W,
    parameter int NUM_REGS = rf_pkg::DEF_NUM_REGS,
    parameter int NUM_COMMIT = 2,
    parameter int AW = rf_pkg::rf_aw(NUM_REGS)
) (
    input  logic [AW-1:0] addr,
    input  logic [NUM_REGS-1:0] busy,
    input  logic [NUM_REGS-1:0][TAG_W-1:0] tags,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] values,
    input  logic rdy,
    input  logic [NUM_COMMIT-1:0] commit_en,
    input  logic [NUM_COMMIT-1:0][AW-1:0] commit_addr,
    input  logic [NUM_COMMIT-1:0][TAG_W-1:0] commit_tag,
    input  logic [NUM_COMMIT-1:0][DATA_W-1:0] commit_data,
    output logic ready,
    output logic [TAG_W-1:0] tag,
    output logic [DATA_W-1:0] value
);
    logic hit;
    logic [DATA_W-1:0] hit_data;
    // Later ports overwrite earlier ones, so the highest matching port supplies the bypass value.
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (rdy && commit_en[k] && commit_addr[k] == addr && commit_tag[k] == tags[addr]) begin
                hit = 1'b1;
                hit_data = commit_data[k];
            end
        end
        ready = !busy[addr] || hit;
        tag = ready ? '0 : tags[addr];
        value = !busy[addr] ? values[addr] : (hit ? hit_data : '0);
    end
endmodule

// File: rtl/renamed_register_file.sv
// renamed_register_file: architectural register file with busy bits and producer rename tags.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying rename, commit, flush,
//        read ports and busy_count.
module renamed_register_file #(
    parameter int DATA_W = rf_pkg::DEF_DATA_W,
    parameter int TAG_W = rf_pkg::DEF_TAG_W,
    parameter int NUM_REGS = rf_pkg::DEF_NUM_REGS,
    parameter int NUM_READ = 2,
    parameter int NUM_COMMIT = 2
) (
    input logic clk,
    input logic rst,
    renamed_register_file_if.slave bus
);
    import rf_pkg::*;
    localparam int AW = rf_aw(NUM_REGS);
    localparam int CW = rf_aw(NUM_REGS + 1);
    logic [NUM_REGS-1:0][DATA_W-1:0] value, value_n;
    logic [NUM_REGS-1:0][TAG_W-1:0] tag, tag_n;
    logic [NUM_REGS-1:0] busy, busy_n;
    logic [CW-1:0] count, count_n;
    logic [NUM_COMMIT-1:0][AW-1:0] c_addr;
    logic [NUM_COMMIT-1:0][TAG_W-1:0] c_tag;
    logic [NUM_COMMIT-1:0][DATA_W-1:0] c_data;
    logic [NUM_READ-1:0][AW-1:0] rd_addr;
    logic [NUM_READ-1:0] rd_ready;
    logic [NUM_READ-1:0][TAG_W-1:0] rd_tag;
    logic [NUM_READ-1:0][DATA_W-1:0] rd_value;
    assign c_addr = bus.commit_addr;
    assign c_tag = bus.commit_tag;
    assign c_data = bus.commit_data;
    assign rd_addr = bus.read_addr;
    assign bus.read_ready = rd_ready;
    assign bus.read_tag = rd_tag;
    assign bus.read_value = rd_value;
    assign bus.busy_count = count;
    // Ordering encodes priority: higher commit port wins the value, rename beats commit clear,
    // flush beats rename. Register 0 is never written so it stays 0 / not busy.
    always_comb begin
        value_n = value;
        busy_n = busy;
        tag_n = tag;
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (bus.commit_en[k] && c_addr[k] != '0) begin
                value_n[c_addr[k]] = c_data[k];
                if (busy[c_addr[k]] && tag[c_addr[k]] == c_tag[k]) busy_n[c_addr[k]] = 1'b0;
            end
        end
        if (bus.rename_en && bus.rename_addr != '0) begin
            busy_n[bus.rename_addr] = 1'b1;
            tag_n[bus.rename_addr] = bus.rename_tag;
        end
        if (bus.flush) begin
            busy_n = '0;
            tag_n = '0;
        end
        count_n = '0;
        for (int i = 0; i < NUM_REGS; i++) count_n = count_n + CW'(busy_n[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            busy <= '0;
            tag <= '0;
            count <= '0;
        end else if (bus.rdy) begin
            value <= value_n;
            busy <= busy_n;
            tag <= tag_n;
            count <= count_n;
        end
    end
    for (genvar j = 0; j < NUM_READ; j++) begin : g_read
        rf_read_port #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_REGS(NUM_REGS), .NUM_COMMIT(NUM_COMMIT), .AW(AW)
        ) u_port (
            .addr(rd_addr[j]),
            .busy(busy),
            .tags(tag),
            .values(value),
            .rdy(bus.rdy),
            .commit_en(bus.commit_en),
            .commit_addr(c_addr),
            .commit_tag(c_tag),
            .commit_data(c_data),
            .ready(rd_ready[j]),
            .tag(rd_tag[j]),
            .value(rd_value[j])
        );
    end
endmodule

// File: tb/tb_renamed_register_file.sv
// tb_renamed_register_file: directed vector table plus corner-case sequences on a default and a wide build.
module tb_renamed_register_file;
    import rf_pkg::*;
    logic clk;
    logic rst;
    int n_vec = 0;
    int n_bad = 0;
    renamed_register_file_if #(.NUM_REGS(32)) if0();
    renamed_register_file_if #(.NUM_READ(4), .NUM_COMMIT(3), .NUM_REGS(64)) if1();
    renamed_register_file u_dut (.clk(clk), .rst(rst), .bus(if0.slave));
    renamed_register_file #(.NUM_READ(4), .NUM_COMMIT(3), .NUM_REGS(64)) u_big (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        int ren, ra, rt;
        int cen, ca0, ct0, cd0, ca1, ct1, cd1;
        int fl, rd0, rd1;
        rf_read_t e0, e1;
        int bc;
    } vec_t;
    vec_t v [18];
    function automatic rf_read_t rr(int r, int t, int d);
        return '{ready: 1'(r), tag: 5'(t), value: 32'(d)};
    endfunction
    function automatic rf_read_t get0(int j);
        return '{ready: if0.read_ready[j], tag: if0.read_tag[j*5 +: 5], value: if0.read_value[j*32 +: 32]};
    endfunction
    function automatic rf_read_t get1(int j);
        return '{ready: if1.read_ready[j], tag: if1.read_tag[j*5 +: 5], value: if1.read_value[j*32 +: 32]};
    endfunction
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic idle0();
        if0.rdy = 1'b1;
        if0.flush = 1'b0;
        if0.rename_en = 1'b0;
        if0.rename_addr = '0;
        if0.rename_tag = '0;
        if0.commit_en = '0;
        if0.commit_addr = '0;
        if0.commit_tag = '0;
        if0.commit_data = '0;
        if0.read_addr = '0;
    endtask
    task automatic idle1();
        if1.rdy = 1'b1;
        if1.flush = 1'b0;
        if1.rename_en = 1'b0;
        if1.rename_addr = '0;
        if1.rename_tag = '0;
        if1.commit_en = '0;
        if1.commit_addr = '0;
        if1.commit_tag = '0;
        if1.commit_data = '0;
        if1.read_addr = '0;
    endtask
    initial begin
        // ren ra rt | cen ca0 ct0 cd0 ca1 ct1 cd1 | fl rd0 rd1 | exp port0, exp port1, busy_count (pre-edge)
        v[0]  = '{0,0,0, 0,0,0,0,      0,0,0,      0,5,0, rr(1,0,0),      rr(1,0,0),      0};
        v[1]  = '{1,3,7, 0,0,0,0,      0,0,0,      0,3,0, rr(1,0,0),      rr(1,0,0),      0};
        v[2]  = '{0,0,0, 0,0,0,0,      0,0,0,      0,3,5, rr(0,7,0),      rr(1,0,0),      1};
        v[3]  = '{0,0,0, 1,3,7,'hDEAD, 0,0,0,      0,3,3, rr(1,0,'hDEAD), rr(1,0,'hDEAD), 1};
        v[4]  = '{0,0,0, 0,0,0,0,      0,0,0,      0,3,0, rr(1,0,'hDEAD), rr(1,0,0),      0};
        v[5]  = '{1,4,2, 0,0,0,0,      0,0,0,      0,4,3, rr(1,0,0),      rr(1,0,'hDEAD), 0};
        v[6]  = '{1,4,9, 0,0,0,0,      0,0,0,      0,4,3, rr(0,2,0),      rr(1,0,'hDEAD), 1};
        v[7]  = '{0,0,0, 2,0,0,0,      4,2,'h11,   0,4,3, rr(0,9,0),      rr(1,0,'hDEAD), 1};
        v[8]  = '{0,0,0, 0,0,0,0,      0,0,0,      1,4,0, rr(0,9,0),      rr(1,0,0),      1};
        v[9]  = '{0,0,0, 0,0,0,0,      0,0,0,      0,4,0, rr(1,0,'h11),   rr(1,0,0),      0};
        v[10] = '{1,6,1, 0,0,0,0,      0,0,0,      0,6,4, rr(1,0,0),      rr(1,0,'h11),   0};
        v[11] = '{1,6,3, 1,6,1,'h55,   0,0,0,      0,6,0, rr(1,0,'h55),   rr(1,0,0),      1};
        v[12] = '{0,0,0, 0,0,0,0,      0,0,0,      0,6,0, rr(0,3,0),      rr(1,0,0),      1};
        v[13] = '{0,0,0, 0,0,0,0,      0,0,0,      1,6,0, rr(0,3,0),      rr(1,0,0),      1};
        v[14] = '{0,0,0, 0,0,0,0,      0,0,0,      0,6,0, rr(1,0,'h55),   rr(1,0,0),      0};
        v[15] = '{1,6,3, 0,0,0,0,      0,0,0,      0,6,4, rr(1,0,'h55),   rr(1,0,'h11),   0};
        v[16] = '{0,0,0, 3,6,3,'h66,   6,3,'h77,   0,6,6, rr(1,0,'h77),   rr(1,0,'h77),   1};
        v[17] = '{0,0,0, 0,0,0,0,      0,0,0,      0,6,4, rr(1,0,'h77),   rr(1,0,'h11),   0};
        rst = 1'b1;
        idle0();
        idle1();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if0.rename_en = 1'(v[i].ren);
            if0.rename_addr = 5'(v[i].ra);
            if0.rename_tag = 5'(v[i].rt);
            if0.commit_en = 2'(v[i].cen);
            if0.commit_addr = {5'(v[i].ca1), 5'(v[i].ca0)};
            if0.commit_tag = {5'(v[i].ct1), 5'(v[i].ct0)};
            if0.commit_data = {32'(v[i].cd1), 32'(v[i].cd0)};
            if0.flush = 1'(v[i].fl);
            if0.read_addr = {5'(v[i].rd1), 5'(v[i].rd0)};
            #1;
            chk($sformatf("v%0d_port0", i), 64'(get0(0)), 64'(v[i].e0));
            chk($sformatf("v%0d_port1", i), 64'(get0(1)), 64'(v[i].e1));
            chk($sformatf("v%0d_busy_count", i), 64'(if0.busy_count), 64'(v[i].bc));
        end
        // rename x1..x10, then flush+commit+rename gated by rdy=0, then the same with rdy=1
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            idle0();
            if0.rename_en = 1'b1;
            if0.rename_addr = 5'(i);
            if0.rename_tag = 5'(i);
        end
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            idle0();
            if0.rdy = 1'(p);
            if0.flush = 1'b1;
            if0.commit_en = 2'b01;
            if0.commit_addr = {5'd0, 5'd2};
            if0.commit_tag = {5'd0, 5'd2};
            if0.commit_data = {32'd0, 32'h77};
            if0.rename_en = 1'b1;
            if0.rename_addr = 5'd11;
            if0.rename_tag = 5'd5;
            if0.read_addr = {5'd11, 5'd2};
            #1;
            chk($sformatf("flush_rdy%0d_count", p), 64'(if0.busy_count), 64'd10);
            chk($sformatf("flush_rdy%0d_x2", p), 64'(get0(0)), 64'(p == 1 ? rr(1, 0, 'h77) : rr(0, 2, 0)));
            chk($sformatf("flush_rdy%0d_x11", p), 64'(get0(1)), 64'(rr(1, 0, 0)));
        end
        @(negedge clk);
        idle0();
        if0.read_addr = {5'd11, 5'd2};
        #1;
        chk("post_flush_count", 64'(if0.busy_count), 64'd0);
        chk("post_flush_x2", 64'(get0(0)), 64'(rr(1, 0, 'h77)));
        chk("post_flush_x11", 64'(get0(1)), 64'(rr(1, 0, 0)));
        @(negedge clk);
        if0.read_addr = {5'd10, 5'd1};
        #1;
        chk("post_flush_x1", 64'(get0(0)), 64'(rr(1, 0, 0)));
        chk("post_flush_x10", 64'(get0(1)), 64'(rr(1, 0, 0)));
        // wide build: dual commit, x0 writes, top register
        @(negedge clk);
        idle1();
        if1.rename_en = 1'b1;
        if1.rename_addr = 6'd40;
        if1.rename_tag = 5'd3;
        if1.read_addr = {6'd40, 6'd0, 6'd0, 6'd0};
        #1;
        chk("big_x40_pre", 64'(get1(3)), 64'(rr(1, 0, 0)));
        @(negedge clk);
        idle1();
        if1.commit_en = 3'b101;
        if1.commit_addr = {6'd40, 6'd0, 6'd40};
        if1.commit_tag = {5'd9, 5'd0, 5'd3};
        if1.commit_data = {32'h200, 32'h0, 32'h100};
        if1.read_addr = {6'd40, 6'd63, 6'd0, 6'd0};
        #1;
        chk("big_bypass_x40", 64'(get1(3)), 64'(rr(1, 0, 'h100)));
        chk("big_x63_idle", 64'(get1(2)), 64'(rr(1, 0, 0)));
        chk("big_count1", 64'(if1.busy_count), 64'd1);
        @(negedge clk);
        idle1();
        if1.rename_en = 1'b1;
        if1.rename_addr = 6'd63;
        if1.rename_tag = 5'd31;
        if1.read_addr = {6'd40, 6'd0, 6'd0, 6'd0};
        #1;
        chk("big_dual_commit_x40", 64'(get1(3)), 64'(rr(1, 0, 'h200)));
        chk("big_count0", 64'(if1.busy_count), 64'd0);
        @(negedge clk);
        idle1();
        if1.rename_en = 1'b1;
        if1.rename_addr = 6'd0;
        if1.rename_tag = 5'd5;
        if1.commit_en = 3'b010;
        if1.commit_data = {32'h0, 32'hFF, 32'h0};
        if1.read_addr = {6'd0, 6'd0, 6'd63, 6'd0};
        #1;
        chk("big_x63_busy", 64'(get1(1)), 64'(rr(0, 31, 0)));
        chk("big_count_x63", 64'(if1.busy_count), 64'd1);
        @(negedge clk);
        idle1();
        #1;
        chk("big_x0", 64'(get1(0)), 64'(rr(1, 0, 0)));
        chk("big_count_x0", 64'(if1.busy_count), 64'd1);
        // reset mid-operation discards same-cycle rename and commit
        @(negedge clk);
        idle0();
        rst = 1'b1;
        if0.rename_en = 1'b1;
        if0.rename_addr = 5'd7;
        if0.rename_tag = 5'd4;
        if0.commit_en = 2'b01;
        if0.commit_addr = {5'd0, 5'd3};
        if0.commit_data = {32'd0, 32'hAB};
        @(negedge clk);
        rst = 1'b0;
        idle0();
        idle1();
        if0.read_addr = {5'd7, 5'd3};
        if1.read_addr = {6'd0, 6'd0, 6'd0, 6'd40};
        #1;
        chk("rst_x3", 64'(get0(0)), 64'(rr(1, 0, 0)));
        chk("rst_x7", 64'(get0(1)), 64'(rr(1, 0, 0)));
        chk("rst_count", 64'(if0.busy_count), 64'd0);
        chk("rst_big_x40", 64'(get1(0)), 64'(rr(1, 0, 0)));
        chk("rst_big_count", 64'(if1.busy_count), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/renamed_register_file.md
# renamed_register_file

Parametrised architectural register file with per-register rename tags for the out-of-order core. It sits between decode/issue, which renames destinations and reads sources, and the ROB commit stage, which retires results. Each entry holds a value, a busy bit and a producer tag. It supports N read ports with same-cycle commit bypass, M commit ports with tag-matched busy clearing, and a global flush.

## Interface
Parameters:
- DATA_W, 32, register value width
- TAG_W, 5, ROB tag width
- NUM_REGS, 32, architectural registers; AW = $clog2(NUM_REGS)
- NUM_READ, 2, read ports
- NUM_COMMIT, 2, commit ports

Ports:
- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, no state changes
- flush  in  1  mispredict recovery; clears all busy bits
- rename_en  in  1  mark rename_addr as busy
- rename_addr  in  AW  destination register
- rename_tag  in  TAG_W  ROB tag of the new producer
- commit_en  in  NUM_COMMIT  per-port commit valid
- commit_addr  in  NUM_COMMIT*AW  retiring destination
- commit_tag  in  NUM_COMMIT*TAG_W  retiring ROB tag
- commit_data  in  NUM_COMMIT*DATA_W  retiring value
- read_addr  in  NUM_READ*AW  source register per port
- read_ready  out  NUM_READ  1 = read_value is valid
- read_tag  out  NUM_READ*TAG_W  producer tag when not ready, else 0
- read_value  out  NUM_READ*DATA_W  value when ready, else 0
- busy_count  out  $clog2(NUM_REGS+1)  number of busy registers

## Operation
- State per entry: value[DATA_W], busy, tag[TAG_W]. Register 0 is hardwired: never busy, value 0, tag 0. Renames and commits to it are ignored.
- Commit port k with en=1 and addr≠0:
  - value[addr] ← data unconditionally.
  - busy[addr] is cleared only if busy=1 and tag[addr]==commit_tag, and no rename to the same addr occurs this cycle.
  - A stale commit (tag mismatch) writes the value and leaves busy/tag untouched.
- Two commit ports naming the same addr: the higher index wins for value. Busy is cleared if either port matches the tag.
- Rename with addr≠0: busy←1, tag←rename_tag. This takes priority over a same-cycle commit clear on the same addr; the commit value is still written.
- Flush: all busy←0 and all tag←0. Same-cycle commits still write values. A same-cycle rename is discarded.
- rdy=0: all state holds, including during flush, rename and commit. Read outputs still reflect the current state.
- Read port j, combinational:
  - If entry not busy: ready=1, value=stored value, tag=0.
  - If busy and some commit port k this cycle has en, addr==read_addr and tag==entry tag (with rdy=1): ready=1, value=commit_data[k] (highest matching k), tag=0. This is the bypass.
  - Otherwise: ready=0, value=0, tag=entry tag.
- The read-side view ignores the same-cycle rename; a rename becomes visible on the next cycle.
- busy_count: registered and updated every enabled cycle to popcount of the next busy vector. It is 0 after reset or flush.

## Timing
- All state updates on posedge clk. Reads are zero-latency: a commit in cycle N is visible through the bypass in cycle N and from storage in N+1.
- Rename in cycle N shows ready=0 with the new tag from N+1.
- rst has priority over everything: values, busy and tags go to 0, and busy_count to 0. After reset every read port outputs ready=1, value=0, tag=0.
- Reset asserted mid-operation discards the same-cycle renames and commits.

## Structure
- Shared package rf_pkg holds the default DATA_W, TAG_W, NUM_REGS, the AW derivation, and a packed struct rf_read_t {ready, tag, value}.
- One sub-module, rf_read_port: per-port lookup plus commit-bypass mux, instantiated NUM_READ times via generate.
- Entry storage, the commit/rename write logic and the busy_count counter live in the top module.

## Test plan
- Reset, then read x5 and x0 → ready=1, value=0, busy_count=0.
- Rename x3 tag 7. Next cycle read x3 → ready=0, tag=7. Commit x3 tag 7 data 0xDEAD → same-cycle read ready=1 value 0xDEAD; next cycle, from storage, value 0xDEAD, busy_count=0.
- Rename x4 tag 2, then rename x4 tag 9, then commit x4 tag 2 data 0x11 → value 0x11 stored, still busy with tag 9, read ready=0.
- Same cycle: commit x6 tag 1 data 0x55 plus rename x6 tag 3 (x6 busy tag 1) → next cycle busy tag 3, stored value 0x55.
- Rename x1..x10, then assert flush with a commit of x2 data 0x77 → all ready=1, x2=0x77, busy_count=0. With rdy=0 on the same stimulus → no state change.
- NUM_READ=4, NUM_COMMIT=3, NUM_REGS=64 build: dual commit to the same addr with ports 0 and 2 → port 2 data stored. Rename/commit to x0 → no effect.
